// File: rtl/cpu_regfile_pkg.sv
// Shared constants for the SuperSpeedCPU register file and its storage cells.
// The address width is derived from the depth, so a non-power-of-two depth still gets enough bits.
package cpu_regfile_pkg;

    localparam int REG_WIDTH = 20;
    localparam int REG_DEPTH = 16;
    localparam int NUM_READ_PORTS = 2;

    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/param_register.sv
// WIDTH-bit storage cell with a load enable and an asynchronous active-high clear.
// The register file uses one of these for each live entry.
module param_register #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (w) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// Register file with one write port, two combinational read ports, an optional
// write-to-read bypass, an optional hardwired zero entry and a per-entry busy scoreboard.
module register_file
    import cpu_regfile_pkg::*;
#(
    parameter int WIDTH    = REG_WIDTH,
    parameter int DEPTH    = REG_DEPTH,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int ADDR_W  = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata0,
    output logic [WIDTH-1:0]  rdata1,
    input  logic              mark,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic              busy0,
    output logic              busy1
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [DEPTH-1:0] busy_q;

    // Entry 0 under ZERO_REG, and any out-of-range address, behaves as constant zero / never busy.
    function automatic logic live_addr(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !(ZERO_REG && (a == '0));
    endfunction

    genvar gi;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (ZERO_REG && gi == 0) begin : g_zero
                assign entry_q[gi] = '0;
                assign busy_q[gi]  = 1'b0;
            end else begin : g_live
                logic busy_reg;
                logic entry_w;
                logic entry_mark;

                assign entry_w    = w && (waddr == ADDR_W'(gi));
                assign entry_mark = mark && (mark_addr == ADDR_W'(gi));

                param_register #(
                    .WIDTH (WIDTH)
                ) u_reg (
                    .clk   (clk),
                    .reset (reset),
                    .w     (entry_w),
                    .d     (wdata),
                    .q     (entry_q[gi])
                );

                // A mark on the same edge as a writeback wins: it is the newer producer.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        busy_reg <= 1'b0;
                    end else if (entry_mark) begin
                        busy_reg <= 1'b1;
                    end else if (entry_w) begin
                        busy_reg <= 1'b0;
                    end
                end

                assign busy_q[gi] = busy_reg;
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_read
            logic [ADDR_W-1:0] addr;
            logic [WIDTH-1:0]  data;
            logic              busy;

            assign addr = (gi == 0) ? raddr0 : raddr1;

            always_comb begin
                data = '0;
                busy = 1'b0;
                if (live_addr(addr)) begin
                    data = entry_q[addr];
                    busy = busy_q[addr];
                    if (BYPASS && w && (waddr == addr)) begin
                        data = wdata;
                        busy = 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign rdata0 = g_read[0].data;
    assign busy0  = g_read[0].busy;
    assign rdata1 = g_read[1].data;
    assign busy1  = g_read[1].busy;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a default instance (bypass, zero entry, 16 deep) and a
// 12-deep instance without bypass or zero entry share every input.
module tb_register_file;

    localparam int W = 20;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          w;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [AW-1:0] raddr0, raddr1;
    logic          mark;
    logic [AW-1:0] mark_addr;

    logic [W-1:0]  rdata0_a, rdata1_a, rdata0_b, rdata1_b;
    logic          busy0_a, busy1_a, busy0_b, busy1_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file dut (
        .clk(clk), .reset(reset), .w(w), .waddr(waddr), .wdata(wdata),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0_a), .rdata1(rdata1_a),
        .mark(mark), .mark_addr(mark_addr), .busy0(busy0_a), .busy1(busy1_a)
    );

    register_file #(.WIDTH(W), .DEPTH(12), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .w(w), .waddr(waddr), .wdata(wdata),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0_b), .rdata1(rdata1_b),
        .mark(mark), .mark_addr(mark_addr), .busy0(busy0_b), .busy1(busy1_b)
    );

    // Reference model: plain arrays of stored values and busy flags per instance.
    logic [W-1:0] mem [2][16];
    bit           bsy [2][16];

    function automatic int cfg_depth(input int inst);
        return (inst == 0) ? 16 : 12;
    endfunction

    function automatic bit usable(input int inst, input int a);
        if (a >= cfg_depth(inst)) return 1'b0;
        if (inst == 0 && a == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] m_rd(input int inst, input int a);
        if (!usable(inst, a)) return '0;
        if (inst == 0 && w && int'(waddr) == a) return wdata;
        return mem[inst][a];
    endfunction

    function automatic bit m_busy(input int inst, input int a);
        if (!usable(inst, a)) return 1'b0;
        if (inst == 0 && w && int'(waddr) == a) return 1'b0;
        return bsy[inst][a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++) begin
                mem[i][j] = '0;
                bsy[i][j] = 1'b0;
            end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (w && usable(i, int'(waddr))) begin
                mem[i][waddr] = wdata;
                bsy[i][waddr] = 1'b0;
            end
            if (mark && usable(i, int'(mark_addr))) bsy[i][mark_addr] = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("a.rdata0", rdata0_a, m_rd(0, int'(raddr0)));
        chk("a.rdata1", rdata1_a, m_rd(0, int'(raddr1)));
        chk("a.busy0", W'(busy0_a), W'(m_busy(0, int'(raddr0))));
        chk("a.busy1", W'(busy1_a), W'(m_busy(0, int'(raddr1))));
        chk("b.rdata0", rdata0_b, m_rd(1, int'(raddr0)));
        chk("b.rdata1", rdata1_b, m_rd(1, int'(raddr1)));
        chk("b.busy0", W'(busy0_b), W'(m_busy(1, int'(raddr0))));
        chk("b.busy1", W'(busy1_b), W'(m_busy(1, int'(raddr1))));
    endtask

    task automatic idle_inputs();
        w = 1'b0; waddr = '0; wdata = '0; mark = 1'b0; mark_addr = '0;
        raddr0 = '0; raddr1 = '0;
    endtask

    typedef struct {
        bit           w;
        int           waddr;
        int           wdata;
        bit           mark;
        int           mark_addr;
        int           raddr0;
        int           raddr1;
        int           exp_rdata0;
        bit           exp_busy0;
        int           exp_rdata1;
        bit           exp_busy1;
    } vec_t;

    vec_t vecs [16];

    initial begin
        // Expected values are the default instance's outputs before the row's edge.
        vecs[0]  = '{1, 5, 54,      0, 0, 5, 5, 54,  0, 54,  0};
        vecs[1]  = '{0, 5, 100,     0, 0, 5, 5, 54,  0, 54,  0};
        vecs[2]  = '{1, 7, 101,     0, 0, 5, 7, 54,  0, 101, 0};
        vecs[3]  = '{0, 0, 0,       0, 0, 7, 7, 101, 0, 101, 0};
        vecs[4]  = '{1, 0, 'hFFFFF, 1, 0, 0, 0, 0,   0, 0,   0};
        vecs[5]  = '{0, 0, 0,       0, 0, 0, 0, 0,   0, 0,   0};
        vecs[6]  = '{0, 0, 0,       1, 9, 9, 0, 0,   0, 0,   0};
        vecs[7]  = '{0, 0, 0,       0, 0, 9, 0, 0,   1, 0,   0};
        vecs[8]  = '{1, 9, 105,     0, 0, 9, 9, 105, 0, 105, 0};
        vecs[9]  = '{0, 0, 0,       0, 0, 9, 0, 105, 0, 0,   0};
        vecs[10] = '{1, 4, 7,       1, 4, 4, 4, 7,   0, 7,   0};
        vecs[11] = '{0, 0, 0,       0, 0, 4, 4, 7,   1, 7,   1};
        vecs[12] = '{1, 6, 33,      1, 2, 2, 6, 0,   0, 33,  0};
        vecs[13] = '{0, 0, 0,       0, 0, 2, 6, 0,   1, 33,  0};
        vecs[14] = '{0, 0, 0,       1, 2, 2, 0, 0,   1, 0,   0};
        vecs[15] = '{0, 0, 0,       0, 0, 2, 0, 0,   1, 0,   0};

        idle_inputs();
        model_clear();
        reset = 1'b1;
        #2;
        chk("reset.rdata0", rdata0_a, '0);
        chk("reset.busy0", W'(busy0_a), '0);
        #5 reset = 1'b0;
        @(posedge clk); #1;

        // Async reset in the middle of a cycle clears data and busy before the next edge.
        w = 1'b1; waddr = 4'd3; wdata = 20'd45; mark = 1'b1; mark_addr = 4'd8;
        @(posedge clk); model_edge(); #1;
        w = 1'b0; mark = 1'b0; raddr0 = 4'd3; raddr1 = 4'd8;
        #1;
        chk("pre_rst.rdata0", rdata0_a, 20'd45);
        chk("pre_rst.busy1", W'(busy1_a), W'(1'b1));
        chk("pre_rst.b.rdata0", rdata0_b, 20'd45);
        #2 reset = 1'b1;
        model_clear();
        #1;
        chk("mid_rst.rdata0", rdata0_a, '0);
        chk("mid_rst.busy1", W'(busy1_a), '0);
        chk("mid_rst.b.rdata0", rdata0_b, '0);
        chk("mid_rst.b.busy1", W'(busy1_b), '0);

        // Reset held across an edge dominates a write and a mark.
        w = 1'b1; waddr = 4'd3; wdata = 20'd45; mark = 1'b1; mark_addr = 4'd8;
        @(posedge clk); #2;
        reset = 1'b0;
        w = 1'b0; mark = 1'b0;
        #1;
        chk("rst_dom.rdata0", rdata0_a, '0);
        chk("rst_dom.busy1", W'(busy1_a), '0);
        chk("rst_dom.b.rdata0", rdata0_b, '0);
        @(posedge clk); model_edge(); #1;

        for (int i = 0; i < 16; i++) begin
            w = vecs[i].w; waddr = AW'(vecs[i].waddr); wdata = W'(vecs[i].wdata);
            mark = vecs[i].mark; mark_addr = AW'(vecs[i].mark_addr);
            raddr0 = AW'(vecs[i].raddr0); raddr1 = AW'(vecs[i].raddr1);
            #3;
            chk($sformatf("vec%0d.rdata0", i), rdata0_a, W'(vecs[i].exp_rdata0));
            chk($sformatf("vec%0d.busy0", i), W'(busy0_a), W'(vecs[i].exp_busy0));
            chk($sformatf("vec%0d.rdata1", i), rdata1_a, W'(vecs[i].exp_rdata1));
            chk($sformatf("vec%0d.busy1", i), W'(busy1_a), W'(vecs[i].exp_busy1));
            chk_model();
            $display("vec %0d: w=%0b waddr=%0d wdata=%0d mark=%0b maddr=%0d r0=%0d->%0d r1=%0d->%0d",
                     i, w, waddr, wdata, mark, mark_addr, raddr0, rdata0_a, raddr1, rdata1_a);
            @(posedge clk); model_edge(); #1;
        end

        // No-bypass instance: a pending write shows the old value until the edge.
        w = 1'b1; waddr = 4'd10; wdata = 20'd101; raddr1 = 4'd10; raddr0 = 4'd14;
        mark = 1'b0;
        #3;
        chk("nb.before_edge", rdata1_b, 20'd0);
        chk("nb.out_of_range", rdata0_b, 20'd0);
        @(posedge clk); model_edge(); #1;
        w = 1'b0;
        #1;
        chk("nb.after_edge", rdata1_b, 20'd101);

        // Out-of-range write and mark on the 12-deep instance are ignored.
        w = 1'b1; waddr = 4'd13; wdata = 20'd999; mark = 1'b1; mark_addr = 4'd13;
        @(posedge clk); model_edge(); #1;
        w = 1'b0; mark = 1'b0; raddr0 = 4'd13;
        #1;
        chk("nb.oor.rdata0", rdata0_b, 20'd0);
        chk("nb.oor.busy0", W'(busy0_b), '0);
        chk("a.in_range13", rdata0_a, 20'd999);

        for (int t = 0; t < 400; t++) begin
            w = $urandom_range(0, 1) == 1;
            waddr = AW'($urandom_range(0, 15));
            wdata = W'($urandom);
            mark = $urandom_range(0, 2) == 0;
            mark_addr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 15));
            raddr0 = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 15));
            raddr1 = ($urandom_range(0, 3) == 0) ? mark_addr : AW'($urandom_range(0, 15));
            #3;
            chk_model();
            if (t % 50 == 0)
                $display("rand %0d: w=%0b waddr=%0d mark=%0b maddr=%0d r0=%0d->%h r1=%0d->%h",
                         t, w, waddr, mark, mark_addr, raddr0, rdata0_a, raddr1, rdata1_a);
            @(posedge clk); model_edge(); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
